// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter. It sends 1 start bit, 8 data bits LSB first,
// an optional parity bit and 1 or 2 stop bits.
// Handshake: the block accepts a byte on a rising clk edge when tx_valid and
// tx_ready are both high. tx_ready is registered and is high only while IDLE.
// When the block is not IDLE it ignores tx_valid and tx_data.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             last_tick;
    logic             parity_bit;

    assign last_tick  = (cnt_q == CNT_LAST);
    assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);

    // Next-state logic. Leaving a state clears the bit-period counter and the bit index.
    // In STOP the bit index counts stop bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d = START;
                    data_d  = tx_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (last_tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PAR : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PAR: begin
                if (last_tick) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next state. This way tx and
    // tx_ready change on the same edge as the state register.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == IDLE);
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[idx_d];
            PAR:     tx_d = parity_bit;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, data latch and the registered outputs.
    // Reset puts the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    assign tx        = tx_q;
    assign tx_ready  = ready_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: exercises four uart_tx configurations that share one clock and one reset.
// cfg0: 4 clk/bit, no parity, 1 stop. cfg1: even parity. cfg2: odd parity.
// cfg3: no parity, 2 stop bits.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] tx_w;
  logic [3:0] rdy_w;
  logic [3:0] busy_w;
  logic [2:0] st_w [4];

  int n_checks;
  int n_fail;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_cfg0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .dbg_state(st_w[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_cfg1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .dbg_state(st_w[1]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_cfg2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .dbg_state(st_w[2]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_cfg3 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .dbg_state(st_w[3]));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cfg;
    logic [7:0] dat;
    logic       par;
    int         len;
    logic       poke;
    logic [7:0] poke_val;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic parity_en(input int c);
    return (c == 1) || (c == 2);
  endfunction

  // Expected line level for bit slot b of a frame.
  function automatic logic frame_bit(input int c, input logic [7:0] d, input logic p, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && parity_en(c)) return p;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the handshake edge. Checks every cycle of the frame, then
  // the first idle cycle after it.
  task automatic check_frame(input int c, input logic [7:0] d, input logic p, input int len,
                             input logic poke, input logic [7:0] poke_val, input string tag);
    for (int k = 0; k < len; k++) begin
      if (poke && k == len / 2) begin
        data[c]  = poke_val;
        valid[c] = 1'b1;
      end
      if (poke && k == len / 2 + 2) valid[c] = 1'b0;
      chk($sformatf("%s tx c%0d", tag, k), 32'(tx_w[c]), 32'(frame_bit(c, d, p, k / 4)));
      chk($sformatf("%s busy c%0d", tag, k), 32'(busy_w[c]), 32'd1);
      chk($sformatf("%s rdy c%0d", tag, k), 32'(rdy_w[c]), 32'd0);
      tick();
    end
    chk({tag, " idle tx"}, 32'(tx_w[c]), 32'd1);
    chk({tag, " idle rdy"}, 32'(rdy_w[c]), 32'd1);
    chk({tag, " idle busy"}, 32'(busy_w[c]), 32'd0);
  endtask

  // driver: waits for tx_ready (bounded), presents the byte for one edge, then checks the frame
  task automatic send(input int c, input logic [7:0] d, input logic p, input int len,
                      input logic poke, input logic [7:0] poke_val, input string tag);
    int waited;
    waited = 0;
    while (!rdy_w[c] && waited < 200) begin
      tick();
      waited++;
    end
    chk({tag, " ready wait"}, 32'(rdy_w[c]), 32'd1);
    data[c]  = d;
    valid[c] = 1'b1;
    tick();
    valid[c] = 1'b0;
    check_frame(c, d, p, len, poke, poke_val, tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    valid    = '0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    rst_n = 1'b0;

    // directed vectors: cfg, byte, hand-computed parity, frame length, mid-frame poke
    vecs[0] = '{0, 8'h55, 1'b0, 40, 1'b0, 8'h00};
    vecs[1] = '{1, 8'h07, 1'b1, 44, 1'b0, 8'h00};
    vecs[2] = '{2, 8'h07, 1'b0, 44, 1'b0, 8'h00};
    vecs[3] = '{3, 8'hA3, 1'b0, 44, 1'b0, 8'h00};
    vecs[4] = '{1, 8'hA3, 1'b0, 44, 1'b0, 8'h00};
    vecs[5] = '{2, 8'h80, 1'b0, 44, 1'b0, 8'h00};
    vecs[6] = '{1, 8'h80, 1'b1, 44, 1'b0, 8'h00};
    vecs[7] = '{0, 8'h00, 1'b0, 40, 1'b0, 8'h00};
    vecs[8] = '{0, 8'hFF, 1'b0, 40, 1'b0, 8'h00};
    vecs[9] = '{0, 8'h3C, 1'b0, 40, 1'b1, 8'hC3};

    // reset state
    repeat (3) tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("reset tx cfg%0d", c), 32'(tx_w[c]), 32'd1);
      chk($sformatf("reset rdy cfg%0d", c), 32'(rdy_w[c]), 32'd0);
      chk($sformatf("reset busy cfg%0d", c), 32'(busy_w[c]), 32'd0);
    end
    rst_n = 1'b1;
    chk("rdy before first edge", 32'(rdy_w[0]), 32'd0);
    tick();
    chk("rdy after first edge", 32'(rdy_w[0]), 32'd1);
    chk("tx idle after reset", 32'(tx_w[0]), 32'd1);

    // table-driven frames
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].cfg, vecs[i].dat, vecs[i].par, vecs[i].len, vecs[i].poke,
           vecs[i].poke_val, $sformatf("vec%0d", i));
      tick();
    end

    // back-to-back: tx_valid held high, 0x01 followed by 0xFF
    data[0]  = 8'h01;
    valid[0] = 1'b1;
    tick();
    data[0] = 8'hFF;
    check_frame(0, 8'h01, 1'b0, 40, 1'b0, 8'h00, "b2b first");
    tick();
    valid[0] = 1'b0;
    check_frame(0, 8'hFF, 1'b0, 40, 1'b0, 8'h00, "b2b second");

    // reset during DATA bit 4 of 0x0F
    tick();
    data[0]  = 8'h0F;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    repeat (21) tick();
    chk("pre-reset in bit4 tx", 32'(tx_w[0]), 32'd0);
    chk("pre-reset busy", 32'(busy_w[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset tx", 32'(tx_w[0]), 32'd1);
    chk("async reset busy", 32'(busy_w[0]), 32'd0);
    chk("async reset rdy", 32'(rdy_w[0]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      chk($sformatf("post-reset tx c%0d", k), 32'(tx_w[0]), 32'd1);
      chk($sformatf("post-reset busy c%0d", k), 32'(busy_w[0]), 32'd0);
      chk($sformatf("post-reset rdy c%0d", k), 32'(rdy_w[0]), 32'd1);
    end
    send(0, 8'h0F, 1'b0, 40, 1'b0, 8'h00, "after reset");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog so that the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
